// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and the tie-break helper for the IF/D memory port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RSP
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_D
    } mem_owner_t;

    // Chooses who gets the next access. A lone requester always wins. On a tie,
    // data either wins outright or the two alternate, based on who went last.
    function automatic mem_owner_t pick_owner(
        input logic       if_req,
        input logic       d_req,
        input mem_owner_t last_owner,
        input logic       data_priority
    );
        mem_owner_t sel;
        if (if_req && d_req) begin
            if (data_priority) begin
                sel = OWNER_D;
            end else begin
                sel = (last_owner == OWNER_D) ? OWNER_IF : OWNER_D;
            end
        end else if (d_req) begin
            sel = OWNER_D;
        end else begin
            sel = OWNER_IF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Purpose: counts cycles spent waiting for a memory response and flags a hung access.
// Latency: expired is combinational, high in the TIMEOUT-th consecutive enabled cycle.
// Backpressure: none; clear wins over enable.
//
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   clear         zero the count (used whenever the arbiter is not waiting)
//   enable        count this cycle
//   expired       the current enabled cycle is the TIMEOUT-th one
module mem_port_arbiter_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // The count holds the number of enabled cycles already completed, so the
    // TIMEOUT-th cycle is the one where the count equals TIMEOUT-1.
    assign expired = enable && (count == LAST_CNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch (IF) and data (D), one access outstanding.
// Latency: zero-wait memory gives gnt 1 cycle and rvalid 3 cycles after req; next issue 1 cycle after rvalid.
// Backpressure: mem_ready low holds the request in ISSUE with fields frozen; requesters hold req until gnt.
//
// Ports:
//   clock, reset                         clock and asynchronous active-high reset
//   if_req/if_addr -> if_gnt             IF read request and 1-cycle accept pulse
//   if_rvalid/if_rdata                   IF read completion, registered
//   d_req/d_we/d_addr/d_wdata/d_be       D load/store request
//   d_gnt, d_rvalid/d_rdata              D accept pulse and completion (rdata 0 for stores)
//   mem_req/we/addr/wdata/be, mem_ready  memory request side
//   mem_rvalid/mem_rdata                 memory response side
//   bus_err                              sticky timeout / stray-response flag, cleared only by reset
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DATA_PRIORITY = 0,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    arb_state_t        state;
    mem_owner_t        owner;
    mem_owner_t        last_owner;
    mem_owner_t        next_owner;
    mem_req_t          req_q;
    mem_req_t          next_req;
    logic              mem_req_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              bus_err_q;
    logic [DATA_W-1:0] rsp_data;
    logic              wdog_expired;

    mem_port_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != ARB_WAIT_RSP),
        .enable  (state == ARB_WAIT_RSP),
        .expired (wdog_expired)
    );

    assign next_owner = pick_owner(if_req, d_req, last_owner, DATA_PRIORITY != 0);

    // Request fields captured in IDLE; IF accesses are always full-width reads.
    always_comb begin
        next_req = '0;
        if (next_owner == OWNER_D) begin
            next_req.we    = d_we;
            next_req.addr  = d_addr;
            next_req.wdata = d_wdata;
            next_req.be    = d_be;
        end else begin
            next_req.we    = 1'b0;
            next_req.addr  = if_addr;
            next_req.wdata = '0;
            next_req.be    = '1;
        end
    end

    // Stores and aborted accesses complete with zero data.
    assign rsp_data = (mem_rvalid && !req_q.we) ? mem_rdata : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_D;
            last_owner  <= OWNER_D;
            req_q       <= '0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;

            // Any response arriving with nothing outstanding is stray.
            if (mem_rvalid && (state != ARB_WAIT_RSP)) begin
                bus_err_q <= 1'b1;
            end

            case (state)
                ARB_IDLE: begin
                    if (if_req || d_req) begin
                        owner     <= next_owner;
                        req_q     <= next_req;
                        mem_req_q <= 1'b1;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_ready) begin
                        last_owner <= owner;
                        mem_req_q  <= 1'b0;
                        state      <= ARB_WAIT_RSP;
                    end
                end
                ARB_WAIT_RSP: begin
                    // A real response in the expiry cycle wins over the abort.
                    if (mem_rvalid || wdog_expired) begin
                        if (owner == OWNER_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= rsp_data;
                        end else begin
                            d_rvalid_q  <= 1'b1;
                            d_rdata_q   <= rsp_data;
                        end
                        if (!mem_rvalid) begin
                            bus_err_q <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Accept is the memory's handshake, so the grant follows mem_ready directly.
    assign if_gnt    = (state == ARB_ISSUE) && mem_ready && (owner == OWNER_IF);
    assign d_gnt     = (state == ARB_ISSUE) && mem_ready && (owner == OWNER_D);
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter (round-robin and data-priority instances).
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpressure: memory stalls and missing responses are driven cycle by cycle from each scenario.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, bus_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        p_if_gnt, p_if_rvalid, p_d_gnt, p_d_rvalid, p_mem_req, p_mem_we, p_bus_err;
    logic [31:0] p_if_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_be;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT(4)) dut_prio (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
        .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_be(p_mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(p_bus_err)
    );

    // {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req} of the round-robin instance
    function automatic logic [4:0] flags();
        return {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    // Leaves the bench 1 unit after a rising edge with reset just released: cycle 0 starts here.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({flags(), mem_we, bus_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000000", {flags(), mem_we, bus_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h be=%h if_rdata=%h d_rdata=%h expected all 0",
                     mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_if_read();
        logic [4:0] exp [0:4];
        exp = '{5'b00000, 5'b10001, 5'b00000, 5'b01000, 5'b00000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if_req     = (c <= 1);
            if_addr    = 32'h0000_0100;
            mem_ready  = 1'b1;
            mem_rvalid = (c == 2);
            mem_rdata  = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clock);
            checks++;
            if (flags() !== exp[c]) begin
                errors++;
                $display("FAIL if_read_flags c%0d got %b expected %b", c, flags(), exp[c]);
            end
            if (c == 1) begin
                checks++;
                if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h0000_0100, 4'hF}) begin
                    errors++;
                    $display("FAIL if_read_fields got we=%b addr=%h be=%h expected we=0 addr=00000100 be=f",
                             mem_we, mem_addr, mem_be);
                end
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL if_read_data got %h expected deadbeef", if_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_store_stall();
        logic [4:0] exp [0:7];
        exp = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b00000, 5'b00010, 5'b00000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            d_req      = (c <= 4);
            d_we       = 1'b1;
            d_addr     = (c >= 2) ? 32'h0000_0999 : 32'h0000_0200;
            d_wdata    = 32'h1234_5678;
            d_be       = 4'b0011;
            mem_ready  = (c >= 4);
            mem_rvalid = (c == 5);
            mem_rdata  = 32'hFFFF_FFFF;
            @(negedge clock);
            checks++;
            if (flags() !== exp[c]) begin
                errors++;
                $display("FAIL store_flags c%0d got %b expected %b", c, flags(), exp[c]);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011}) begin
                    errors++;
                    $display("FAIL store_fields c%0d got we=%b addr=%h wdata=%h be=%b expected we=1 addr=00000200 wdata=12345678 be=0011",
                             c, mem_we, mem_addr, mem_wdata, mem_be);
                end
            end
            if (c == 6) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL store_rdata got %h expected 00000000", d_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_tie_break();
        logic [3:0] exp_rr;
        logic [1:0] exp_pr;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if_req     = 1'b1;
            d_req      = 1'b1;
            d_we       = 1'b0;
            if_addr    = 32'h0000_1000;
            d_addr     = 32'h0000_2000;
            mem_ready  = 1'b1;
            mem_rvalid = ((c % 3) == 2);
            mem_rdata  = 32'(c);
            @(negedge clock);
            exp_rr = {(c == 1 || c == 7), (c == 4 || c == 10), (c == 3 || c == 9), (c == 6)};
            checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== exp_rr) begin
                errors++;
                $display("FAIL rr_order c%0d got if_gnt,d_gnt,if_rv,d_rv=%b expected %b",
                         c, {if_gnt, d_gnt, if_rvalid, d_rvalid}, exp_rr);
            end
            exp_pr = {1'b0, ((c % 3) == 1)};
            checks++;
            if ({p_if_gnt, p_d_gnt} !== exp_pr) begin
                errors++;
                $display("FAIL prio_order c%0d got if_gnt,d_gnt=%b expected %b", c, {p_if_gnt, p_d_gnt}, exp_pr);
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 32'd2) begin
                    errors++;
                    $display("FAIL rr_if_rdata got %h expected 00000002", if_rdata);
                end
            end
            if (c == 6) begin
                checks++;
                if (d_rdata !== 32'd5) begin
                    errors++;
                    $display("FAIL rr_d_rdata got %h expected 00000005", d_rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [4:0] exp [0:9];
        exp = '{5'b00000, 5'b00101, 5'b00000, 5'b00000, 5'b00000,
                5'b00000, 5'b00010, 5'b10001, 5'b00000, 5'b01000};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            d_req      = (c <= 1);
            d_we       = 1'b0;
            d_addr     = 32'h0000_0300;
            if_req     = (c == 6 || c == 7);
            if_addr    = 32'h0000_0400;
            mem_ready  = 1'b1;
            mem_rvalid = (c == 8);
            mem_rdata  = (c == 8) ? 32'hCAFE_F00D : 32'hBAD0_BAD0;
            @(negedge clock);
            checks++;
            if (flags() !== exp[c]) begin
                errors++;
                $display("FAIL timeout_flags c%0d got %b expected %b", c, flags(), exp[c]);
            end
            checks++;
            if (bus_err !== (c >= 6)) begin
                errors++;
                $display("FAIL timeout_bus_err c%0d got %b expected %b", c, bus_err, (c >= 6));
            end
            if (c == 6) begin
                checks++;
                if (d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL timeout_rdata got %h expected 00000000", d_rdata);
                end
            end
            if (c == 9) begin
                checks++;
                if (if_rdata !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL after_timeout_rdata got %h expected cafef00d", if_rdata);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_stray_idle();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = (c == 0);
            mem_rdata  = 32'h0000_0055;
            @(negedge clock);
            checks++;
            if ({flags(), bus_err} !== {5'b00000, (c >= 1)}) begin
                errors++;
                $display("FAIL stray_idle c%0d got flags,bus_err=%b expected %b",
                         c, {flags(), bus_err}, {5'b00000, (c >= 1)});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        // cycle 0: request plus a stray response, so bus_err is set before the reset
        if_req = 1'b1; if_addr = 32'h0000_0500; mem_ready = 1'b1; mem_rvalid = 1'b1;
        tick();
        // cycle 1: ISSUE, accepted
        mem_rvalid = 1'b0;
        @(negedge clock);
        checks++;
        if ({if_gnt, bus_err} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre got if_gnt,bus_err=%b expected 11", {if_gnt, bus_err});
        end
        tick();
        // cycle 2: WAIT_RSP, then reset asserted mid-cycle
        if_req = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({flags(), bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_async got flags,bus_err=%b expected 000000", {flags(), bus_err});
        end
        tick();
        tick();
        reset = 1'b0;
        // late response from the dropped access
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        @(negedge clock);
        checks++;
        if ({flags(), bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_late0 got flags,bus_err=%b expected 000000", {flags(), bus_err});
        end
        tick();
        mem_rvalid = 1'b0;
        @(negedge clock);
        checks++;
        if ({flags(), bus_err} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid_late1 got flags,bus_err=%b expected 000001", {flags(), bus_err});
        end
        tick();
        @(negedge clock);
        checks++;
        if ({flags(), bus_err} !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid_late2 got flags,bus_err=%b expected 000001", {flags(), bus_err});
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_if_read();
        test_store_stall();
        test_tie_break();
        test_timeout();
        test_stray_idle();
        test_reset_mid_txn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
